// File: rtl/hcsr04_pkg.sv
// rtl/hcsr04_pkg.sv - shared types, constants and helpers for the HC-SR04 ranger
package hcsr04_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    FINISH,
    HOLDOFF
  } hcsr04_state_e;

  // Fixed-point shift used by the cycles-to-millimetres multiply
  localparam int DIST_SHIFT = 24;

  // Half the speed of sound in mm/s (the echo covers the distance twice)
  localparam longint unsigned SOUND_HALF_MM_PER_S = 64'd171500;

  // Microseconds to clock cycles; the clock is a whole number of MHz
  function automatic longint unsigned us_to_cyc(input longint unsigned us,
                                                input longint unsigned clk_hz);
    return us * (clk_hz / 64'd1_000_000);
  endfunction

endpackage

// File: rtl/hcsr04_ranger_core_echo_sync.sv
// rtl/hcsr04_ranger_core_echo_sync.sv - ECHO pin synchronizer with rise/fall edge pulses
module hcsr04_echo_sync (
  input  logic clock,
  input  logic reset,
  input  logic echo,
  output logic echo_s,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  // two-stage synchronizer followed by one registered history bit for edge detection
  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= echo;
      sync <= meta;
      prev <= sync;
    end
  end

  // both edges come from the same registered pair, so rise and fall share one latency
  assign echo_s = sync;
  assign rise   = sync & ~prev;
  assign fall   = ~sync & prev;

endmodule

// File: rtl/hcsr04_ranger_core.sv
// rtl/hcsr04_ranger_core.sv - HC-SR04 trigger/echo timing engine; HCSR04_AVG_EN enables 4-sample distance averaging
module hcsr04_ranger_core
  import hcsr04_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned TRIG_US     = 10,
  parameter int unsigned TIMEOUT_US  = 38000,
  parameter int unsigned HOLDOFF_US  = 60000,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             continuous,
  input  logic             echo,
  output logic             trig,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] echo_cycles,
  output logic [15:0]      distance_mm,
  output logic [15:0]      meas_count
);

  localparam logic [CNT_W-1:0] TRIG_CYC    = CNT_W'(us_to_cyc(64'(TRIG_US), 64'(CLK_FREQ_HZ)));
  localparam logic [CNT_W-1:0] TIMEOUT_CYC = CNT_W'(us_to_cyc(64'(TIMEOUT_US), 64'(CLK_FREQ_HZ)));
  localparam logic [CNT_W-1:0] HOLDOFF_CYC = CNT_W'(us_to_cyc(64'(HOLDOFF_US), 64'(CLK_FREQ_HZ)));
  localparam logic [CNT_W-1:0] TRIG_LAST    = TRIG_CYC - CNT_W'(1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = TIMEOUT_CYC - CNT_W'(1);
  localparam logic [CNT_W-1:0] HOLDOFF_LAST = HOLDOFF_CYC - CNT_W'(1);

  // mm per cycle in 0.24 fixed point; fits 24 bits for any clock above ~172 kHz
  localparam longint unsigned       DIST_K_FULL = (SOUND_HALF_MM_PER_S << DIST_SHIFT) / 64'(CLK_FREQ_HZ);
  localparam logic [DIST_SHIFT-1:0] DIST_K      = DIST_SHIFT'(DIST_K_FULL);
  localparam int                    PROD_W      = CNT_W + DIST_SHIFT;

  hcsr04_state_e    state;
  hcsr04_state_e    state_next;
  logic [CNT_W-1:0] cnt;
  logic             echo_s;
  logic             echo_rise;
  logic             echo_fall;
  logic             to_hit;
  logic             to_flag;
  logic             rose;
  logic [CNT_W-1:0] echo_val;
  logic [CNT_W-1:0] dist_src;
  logic [PROD_W-1:0] prod;
  logic [CNT_W-1:0] mm_full;
  logic [15:0]      mm_sat;

  hcsr04_echo_sync u_echo_sync (
    .clock  (clock),
    .reset  (reset),
    .echo   (echo),
    .echo_s (echo_s),
    .rise   (echo_rise),
    .fall   (echo_fall)
  );

  // state register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // next-state logic; to_hit marks a transition into FINISH caused by a timeout
  always_comb begin
    state_next = state;
    to_hit     = 1'b0;
    case (state)
      IDLE:      if (start) state_next = TRIG;
      TRIG:      if (cnt == TRIG_LAST) state_next = WAIT_RISE;
      WAIT_RISE: begin
        if (echo_rise) begin
          state_next = MEASURE;
        end else if (cnt == TIMEOUT_LAST) begin
          state_next = FINISH;
          to_hit     = 1'b1;
        end
      end
      MEASURE: begin
        if (echo_fall) begin
          state_next = FINISH;
        end else if (cnt >= TIMEOUT_CYC) begin
          state_next = FINISH;
          to_hit     = 1'b1;
        end
      end
      FINISH:    state_next = HOLDOFF;
      HOLDOFF:   if (cnt == HOLDOFF_LAST) state_next = continuous ? TRIG : IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Moore outputs
  always_comb begin
    trig = (state == TRIG);
    busy = (state != IDLE);
  end

  // phase timer restarts on each state change and holds through FINISH so the echo count can be latched
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt     <= '0;
      to_flag <= 1'b0;
      rose    <= 1'b0;
    end else begin
      if (state_next != state) begin
        if (state_next == MEASURE)     cnt <= CNT_W'(1);
        else if (state_next != FINISH) cnt <= '0;
      end else if ((state inside {TRIG, WAIT_RISE, HOLDOFF}) || (state == MEASURE && echo_s)) begin
        cnt <= cnt + CNT_W'(1);
      end

      if (state_next == TRIG && state != TRIG) begin
        to_flag <= 1'b0;
        rose    <= 1'b0;
      end
      if (state == WAIT_RISE && state_next == MEASURE) rose <= 1'b1;
      if (to_hit) to_flag <= 1'b1;
    end
  end

  assign echo_val = rose ? cnt : '0;

`ifdef HCSR04_AVG_EN
  logic [CNT_W-1:0] hist [4];
  logic [2:0]       fill;
  logic [CNT_W-1:0] cand [4];
  logic [2:0]       cand_fill;
  logic [CNT_W+1:0] sum2;
  logic [CNT_W+1:0] sum4;

  // candidate history after this measurement (timeouts leave it untouched) and its mean
  always_comb begin
    if (to_flag) begin
      cand      = hist;
      cand_fill = fill;
    end else begin
      cand[0]   = echo_val;
      cand[1]   = hist[0];
      cand[2]   = hist[1];
      cand[3]   = hist[2];
      cand_fill = (fill == 3'd4) ? 3'd4 : fill + 3'd1;
    end
    sum2 = (CNT_W+2)'(cand[0]) + (CNT_W+2)'(cand[1]);
    sum4 = sum2 + (CNT_W+2)'(cand[2]) + (CNT_W+2)'(cand[3]);
    case (cand_fill)
      3'd1:       dist_src = cand[0];
      3'd2, 3'd3: dist_src = CNT_W'(sum2 >> 1);
      3'd4:       dist_src = CNT_W'(sum4 >> 2);
      default:    dist_src = '0;
    endcase
  end

  // history commits on the same edge that publishes the result
  always_ff @(posedge clock) begin
    if (reset) begin
      hist <= '{default: '0};
      fill <= 3'd0;
    end else if (state == FINISH) begin
      hist <= cand;
      fill <= cand_fill;
    end
  end
`else
  assign dist_src = echo_val;
`endif

  assign prod    = PROD_W'(dist_src) * PROD_W'(DIST_K);
  assign mm_full = CNT_W'(prod >> DIST_SHIFT);
  assign mm_sat  = (mm_full > CNT_W'(16'hFFFF)) ? 16'hFFFF : mm_full[15:0];

  // result registers change only on the edge that raises done
  always_ff @(posedge clock) begin
    if (reset) begin
      done        <= 1'b0;
      timeout     <= 1'b0;
      echo_cycles <= '0;
      distance_mm <= '0;
      meas_count  <= '0;
    end else begin
      done <= 1'b0;
      if (state == FINISH) begin
        done        <= 1'b1;
        timeout     <= to_flag;
        echo_cycles <= echo_val;
        distance_mm <= mm_sat;
        meas_count  <= meas_count + 16'd1;
      end
    end
  end

endmodule
